imem_fetch_port: RTL and testbench

Parametrised instruction memory with a registered read and a valid/ready fetch handshake. It replaces the purely combinational ROM.
- A loader write port fills the array at run time.
- Misaligned and out-of-range fetches are detected and flagged.
- A small response FIFO absorbs back-pressure from IF/ID.
- A flush input discards wrong-path fetches on redirect.

---
 rtl/imem_pkg.sv | 22 ++
 rtl/imem_fetch_port_if.sv | 24 ++
 rtl/imem_rsp_fifo.sv | 64 ++++++
 rtl/imem_fetch_port.sv | 133 +++++++++++++
 tb/tb_imem_fetch_port.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory fetch port.
package imem_pkg;

  localparam int unsigned XLEN = 32;

  // Returned for any fetch that is misaligned or outside the array (addi x0,x0,0).
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  // One fetch response as it travels through the read pipe and response buffer.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic            err;
  } imem_rsp_t;

  localparam int unsigned RSP_W = $bits(imem_rsp_t);

  // Byte-address width for an array of the given size in bytes.
  function automatic int unsigned imem_aw(input int unsigned size_bytes);
    return $clog2(size_bytes);
  endfunction

endpackage

// File: rtl/imem_fetch_port_if.sv
// Fetch request/response handshake between the fetch stage (master) and
// the instruction memory (slave).
interface imem_fetch_port_if;
  import imem_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_pc;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_instr;
  logic            rsp_err;

  modport master (
    output req_valid, req_pc, rsp_ready,
    input  req_ready, rsp_valid, rsp_instr, rsp_err
  );

  modport slave (
    input  req_valid, req_pc, rsp_ready,
    output req_ready, rsp_valid, rsp_instr, rsp_err
  );

endinterface

// File: rtl/imem_rsp_fifo.sv
// Small synchronous response FIFO with flush; storage is not reset, only
// the pointers and occupancy.
module imem_rsp_fifo #(
  parameter  int unsigned DEPTH = 2,
  parameter  int unsigned WIDTH = 33,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             pop_ok;
  logic             push_ok;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy tracking; flush empties the buffer in one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_next(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_next(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/imem_fetch_port.sv
// Byte-addressed instruction memory with a registered read, credit-based
// valid/ready fetch handshake, run-time loader port and response buffer.
module imem_fetch_port
  import imem_pkg::*;
#(
  parameter int unsigned IMEM_SIZE  = 1024,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned AW         = imem_aw(IMEM_SIZE)
) (
  input  logic                clk,
  input  logic                rst_n,
  imem_fetch_port_if.slave    bus,
  input  logic                flush,
  input  logic                ld_we,
  input  logic [AW-1:0]       ld_addr,
  input  logic [XLEN-1:0]     ld_data,
  output logic [15:0]         err_count
);

  localparam int unsigned     CW      = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned     OW      = $clog2(FIFO_DEPTH + 2);
  localparam logic [XLEN-1:0] LAST_PC = XLEN'(IMEM_SIZE - 4);

  logic [7:0]       mem [IMEM_SIZE];
  logic             run;
  logic             accept;
  logic             acc_err;
  logic [AW-1:0]    rd_base;
  logic [AW-1:0]    ld_base;
  imem_rsp_t        acc_rsp;
  imem_rsp_t        push_rsp;
  imem_rsp_t        head;
  logic [RSP_W-1:0] head_bits;
  logic             push;
  logic             inflight;
  logic [CW-1:0]    fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic [OW-1:0]    outstanding;

  // Credits cover both the read stage and buffered responses, so the FIFO can
  // never be asked to hold more than FIFO_DEPTH entries.
  assign outstanding   = OW'(fifo_count) + OW'(inflight);
  assign bus.req_ready = run && !fifo_full && (outstanding < OW'(FIFO_DEPTH))
                         && !ld_we && !flush;
  assign accept        = bus.req_valid && bus.req_ready;

  assign acc_err = (bus.req_pc[1:0] != 2'b00) || (bus.req_pc > LAST_PC);
  assign rd_base = bus.req_pc[AW-1:0] & ~AW'(3);
  assign ld_base = ld_addr & ~AW'(3);

  // Holds off fetch acceptance until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  // Loader write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (ld_we) begin
      mem[ld_base]          <= ld_data[7:0];
      mem[ld_base | AW'(1)] <= ld_data[15:8];
      mem[ld_base | AW'(2)] <= ld_data[23:16];
      mem[ld_base | AW'(3)] <= ld_data[31:24];
    end
  end

  // Little-endian word assembly and error substitution at accept time.
  always_comb begin
    acc_rsp       = '0;
    acc_rsp.err   = acc_err;
    acc_rsp.instr = acc_err ? INSTR_NOP
                            : {mem[rd_base | AW'(3)], mem[rd_base | AW'(2)],
                               mem[rd_base | AW'(1)], mem[rd_base]};
  end

  // With latency 1 the FIFO entry itself is the read register; latency 2 adds
  // one stage in front of it, counted as in-flight for credit purposes.
  if (RD_LATENCY > 1) begin : g_stage
    imem_rsp_t stg_rsp;
    logic      stg_vld;

    // Extra read stage, cleared on flush.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stg_vld <= 1'b0;
        stg_rsp <= '0;
      end else if (flush) begin
        stg_vld <= 1'b0;
      end else begin
        stg_vld <= accept;
        if (accept) stg_rsp <= acc_rsp;
      end
    end

    assign push     = stg_vld;
    assign push_rsp = stg_rsp;
    assign inflight = stg_vld;
  end else begin : g_direct
    assign push     = accept;
    assign push_rsp = acc_rsp;
    assign inflight = 1'b0;
  end

  imem_rsp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (RSP_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push),
    .push_data (push_rsp),
    .pop       (bus.rsp_ready),
    .pop_data  (head_bits),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head          = imem_rsp_t'(head_bits);
  assign bus.rsp_valid = !fifo_empty;
  assign bus.rsp_instr = bus.rsp_valid ? head.instr : '0;
  assign bus.rsp_err   = bus.rsp_valid && head.err;

  // Saturating count of accepted errored fetches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      err_count <= '0;
    else if (accept && acc_err && err_count != '1)   err_count <= err_count + 16'd1;
  end

endmodule

// File: tb/tb_imem_fetch_port.sv
// Directed bench for imem_fetch_port: a latency-1/depth-2 instance for the
// main sequence and a latency-2/depth-4 instance for latency and throughput.
module tb_imem_fetch_port;

  localparam int unsigned SZ = 1024;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        ld_we = 1'b0;
  logic [9:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic [15:0] errc_a;
  logic [15:0] errc_b;

  int          total = 0;
  int          bad = 0;
  exp_t        q_a[$];
  exp_t        q_b[$];
  logic [15:0] ecnt_a = '0;
  logic [15:0] ecnt_b = '0;
  logic [7:0]  mdl [SZ];

  imem_fetch_port_if bus_a();
  imem_fetch_port_if bus_b();

  imem_fetch_port #(.IMEM_SIZE(SZ), .RD_LATENCY(1), .FIFO_DEPTH(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a), .flush(flush), .ld_we(ld_we),
    .ld_addr(ld_addr), .ld_data(ld_data), .err_count(errc_a)
  );

  imem_fetch_port #(.IMEM_SIZE(SZ), .RD_LATENCY(2), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b), .flush(flush), .ld_we(ld_we),
    .ld_addr(ld_addr), .ld_data(ld_data), .err_count(errc_b)
  );

  always #5 clk = ~clk;

  function automatic exp_t exp_rsp(input logic [31:0] pc);
    exp_t        r;
    int unsigned b;
    b       = int'({pc[9:2], 2'b00});
    r.err   = (pc[1:0] != 2'b00) || (pc > 32'(SZ - 4));
    r.instr = r.err ? 32'h0000_0013 : {mdl[b+3], mdl[b+2], mdl[b+1], mdl[b]};
    return r;
  endfunction

  // Memory model, scoreboard push on accept and pop/compare on response (A).
  always @(negedge clk) begin
    exp_t        e;
    int unsigned b;
    if (ld_we) begin
      b = int'({ld_addr[9:2], 2'b00});
      mdl[b]   = ld_data[7:0];
      mdl[b+1] = ld_data[15:8];
      mdl[b+2] = ld_data[23:16];
      mdl[b+3] = ld_data[31:24];
    end
    if (!rst_n) begin
      q_a.delete();
      ecnt_a = '0;
    end else if (flush) begin
      q_a.delete();
    end else begin
      if (bus_a.rsp_valid && bus_a.rsp_ready) begin
        total++;
        assert (q_a.size() != 0) else begin
          bad++;
          $error("FAIL rsp_a_unexpected observed=%h expected=none", bus_a.rsp_instr);
        end
        if (q_a.size() != 0) begin
          e = q_a.pop_front();
          total++;
          assert (bus_a.rsp_instr === e.instr && bus_a.rsp_err === e.err) else begin
            bad++;
            $error("FAIL rsp_a_data observed=%h/%b expected=%h/%b",
                   bus_a.rsp_instr, bus_a.rsp_err, e.instr, e.err);
          end
        end
      end
      if (bus_a.req_valid && bus_a.req_ready) begin
        e = exp_rsp(bus_a.req_pc);
        q_a.push_back(e);
        if (e.err && ecnt_a != 16'hFFFF) ecnt_a++;
      end
    end
  end

  // Scoreboard for instance B.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q_b.delete();
      ecnt_b = '0;
    end else if (flush) begin
      q_b.delete();
    end else begin
      if (bus_b.rsp_valid && bus_b.rsp_ready) begin
        total++;
        assert (q_b.size() != 0) else begin
          bad++;
          $error("FAIL rsp_b_unexpected observed=%h expected=none", bus_b.rsp_instr);
        end
        if (q_b.size() != 0) begin
          e = q_b.pop_front();
          total++;
          assert (bus_b.rsp_instr === e.instr && bus_b.rsp_err === e.err) else begin
            bad++;
            $error("FAIL rsp_b_data observed=%h/%b expected=%h/%b",
                   bus_b.rsp_instr, bus_b.rsp_err, e.instr, e.err);
          end
        end
      end
      if (bus_b.req_valid && bus_b.req_ready) begin
        e = exp_rsp(bus_b.req_pc);
        q_b.push_back(e);
        if (e.err && ecnt_b != 16'hFFFF) ecnt_b++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [9:0] a, input logic [31:0] d);
    ld_we   = 1'b1;
    ld_addr = a;
    ld_data = d;
    tick();
    ld_we   = 1'b0;
  endtask

  task automatic fetch_a(input logic [31:0] pc);
    bit acc;
    acc = 1'b0;
    bus_a.req_valid = 1'b1;
    bus_a.req_pc    = pc;
    for (int n = 0; n < 40 && !acc; n++) begin
      #1;
      acc = bus_a.req_ready;
      tick();
    end
    bus_a.req_valid = 1'b0;
    total++;
    assert (acc) else begin
      bad++;
      $error("FAIL fetch_a_accept pc=%h observed=not_accepted expected=accepted", pc);
    end
  endtask

  task automatic drain();
    bus_a.rsp_ready = 1'b1;
    bus_b.rsp_ready = 1'b1;
    for (int n = 0; n < 40 && (q_a.size() != 0 || q_b.size() != 0); n++) tick();
    tick();
    total++;
    assert (q_a.size() == 0 && q_b.size() == 0) else begin
      bad++;
      $error("FAIL drain observed=%0d/%0d pending expected=0/0", q_a.size(), q_b.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_a.req_valid = 1'b0; bus_a.req_pc = '0; bus_a.rsp_ready = 1'b1;
    bus_b.req_valid = 1'b0; bus_b.req_pc = '0; bus_b.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
    check("rst_rsp_instr", bus_a.rsp_instr, 32'd0);
    check("rst_rsp_err",   32'(bus_a.rsp_err), 32'd0);
    check("rst_err_count", 32'(errc_a), 32'd0);
    check("rst_req_ready", 32'(bus_a.req_ready), 32'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", 32'(bus_a.req_ready), 32'd1);

    for (int i = 0; i < 8; i++) load(10'(i * 4), 32'h1000_0000 + 32'(i) * 32'h0101);
    load(10'(SZ - 4), 32'hDEAD_BEEF);
    load(10'd4, 32'h0040_0093);

    // Latency-1 fetch of the freshly loaded word.
    bus_a.req_valid = 1'b1;
    bus_a.req_pc    = 32'd4;
    #1 check("acc_ready", 32'(bus_a.req_ready), 32'd1);
    tick();
    bus_a.req_valid = 1'b0;
    check("lat1_valid", 32'(bus_a.rsp_valid), 32'd1);
    check("lat1_instr", bus_a.rsp_instr, 32'h0040_0093);
    check("lat1_err",   32'(bus_a.rsp_err), 32'd0);
    drain();

    // Error cases and the last legal word.
    fetch_a(32'd6);          drain(); check("err_misaligned_cnt", 32'(errc_a), 32'd1);
    fetch_a(32'(SZ - 2));    drain(); check("err_range_cnt", 32'(errc_a), 32'd2);
    fetch_a(32'(SZ - 4));    drain(); check("last_word_cnt", 32'(errc_a), 32'd2);
    fetch_a(32'h8000_0000);  drain(); check("err_upper_cnt", 32'(errc_a), 32'(ecnt_a));

    // Back-to-back throughput.
    bus_a.req_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus_a.req_pc = 32'(i * 4);
      #1 check("b2b_ready", 32'(bus_a.req_ready), 32'd1);
      tick();
    end
    bus_a.req_valid = 1'b0;
    drain();

    // Back-pressure: only two fetches outstanding, head held stable.
    bus_a.rsp_ready = 1'b0;
    bus_a.req_valid = 1'b1;
    bus_a.req_pc = 32'd0; #1 check("bp_ready0", 32'(bus_a.req_ready), 32'd1); tick();
    bus_a.req_pc = 32'd4; #1 check("bp_ready1", 32'(bus_a.req_ready), 32'd1); tick();
    bus_a.req_pc = 32'd8; #1 check("bp_full_ready", 32'(bus_a.req_ready), 32'd0); tick();
    check("bp_hold_ready", 32'(bus_a.req_ready), 32'd0);
    check("bp_hold_instr", bus_a.rsp_instr, 32'h1000_0000);
    tick();
    check("bp_hold_valid", 32'(bus_a.rsp_valid), 32'd1);
    check("bp_stable_instr", bus_a.rsp_instr, 32'h1000_0000);
    bus_a.rsp_ready = 1'b1;
    #1 check("bp_pop_credit_late", 32'(bus_a.req_ready), 32'd0);
    fetch_a(32'd8);
    drain();

    // Flush with two outstanding and a pop in the flush cycle.
    bus_a.rsp_ready = 1'b0;
    fetch_a(32'd0);
    fetch_a(32'd4);
    flush = 1'b1;
    bus_a.rsp_ready = 1'b1;
    bus_a.req_valid = 1'b1;
    bus_a.req_pc    = 32'd12;
    #1 check("flush_ready", 32'(bus_a.req_ready), 32'd0);
    tick();
    flush = 1'b0;
    bus_a.req_valid = 1'b0;
    check("flush_rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
    check("flush_err_count", 32'(errc_a), 32'(ecnt_a));
    fetch_a(32'd8);
    drain();
    check("flush_no_stale", 32'(bus_a.rsp_valid), 32'd0);

    // Loader blocks the same-cycle fetch; next cycle sees the new word.
    ld_we = 1'b1; ld_addr = 10'd12; ld_data = 32'hCAFE_F00D;
    bus_a.req_valid = 1'b1;
    bus_a.req_pc    = 32'd12;
    #1 check("ld_block_ready", 32'(bus_a.req_ready), 32'd0);
    tick();
    ld_we = 1'b0;
    #1 check("ld_next_ready", 32'(bus_a.req_ready), 32'd1);
    tick();
    bus_a.req_valid = 1'b0;
    check("ld_new_word", bus_a.rsp_instr, 32'hCAFE_F00D);
    drain();

    // A later load does not disturb an already-fetched word.
    bus_a.rsp_ready = 1'b0;
    fetch_a(32'd16);
    load(10'd16, 32'h7777_1111);
    check("inflight_hold", bus_a.rsp_instr, 32'h1000_0404);
    drain();

    // Reset in the middle of traffic.
    bus_a.rsp_ready = 1'b0;
    fetch_a(32'd6);
    fetch_a(32'd0);
    rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
    check("midrst_err_count", 32'(errc_a), 32'd0);
    check("midrst_req_ready", 32'(bus_a.req_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    bus_a.rsp_ready = 1'b1;
    fetch_a(32'd4);
    check("midrst_array_kept", bus_a.rsp_instr, 32'h0040_0093);
    drain();

    // Latency-2 instance: timing of first response, then full throughput.
    bus_b.rsp_ready = 1'b1;
    bus_b.req_valid = 1'b1;
    bus_b.req_pc    = 32'd0;
    #1 check("b_ready", 32'(bus_b.req_ready), 32'd1);
    tick();
    bus_b.req_valid = 1'b0;
    check("b_lat_early", 32'(bus_b.rsp_valid), 32'd0);
    tick();
    check("b_lat_on_time", 32'(bus_b.rsp_valid), 32'd1);
    check("b_lat_instr", bus_b.rsp_instr, 32'h1000_0000);
    drain();
    bus_b.req_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus_b.req_pc = 32'(i * 4);
      #1 check("b_b2b_ready", 32'(bus_b.req_ready), 32'd1);
      tick();
    end
    bus_b.req_valid = 1'b0;
    drain();
    check("b_err_count", 32'(errc_b), 32'(ecnt_b));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
